// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the mem_copy_dma block-copy
//               engine. Holds the FSM state encoding and the default memory
//               geometry (256 x 8 single-port data memory).
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma
// Description : Block-copy initiator for the single-port data memory. Copies
//               Len bytes from SrcAddr to DstAddr, one byte every two cycles
//               (READ then WRITE), with memmove semantics: when the
//               destination lies above the source the copy runs from the
//               last byte downwards so that overlapping regions stay intact.
//
// Ports       : CLK, reset       - clock, synchronous active-high reset
//               Start            - copy request, sampled only in IDLE
//               SrcAddr, DstAddr - first source / destination byte address
//               Len              - byte count 0..256 (larger values clamp)
//               Busy, Done       - copy in progress / one-cycle completion
//               DataAddress      - memory address
//               ReadMem, WriteMem- memory read / write enables
//               DataIn           - memory write data
//               DataOut          - memory read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma #(
  parameter int ADDR_W = dma_pkg::ADDR_W,
  parameter int DATA_W = dma_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   Len,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  import dma_pkg::*;

  // Largest legal count: the whole address space.
  localparam logic [ADDR_W:0]   c_FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_PLUS_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_MINUS_ONE = {ADDR_W{1'b1}};

  dma_state_t        r_state;
  dma_state_t        w_next_state;

  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_desc;
  logic [DATA_W-1:0] r_hold;

  logic              w_start_copy;
  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W-1:0] w_len_lo;
  logic              w_desc_start;
  logic [ADDR_W-1:0] w_src_first;
  logic [ADDR_W-1:0] w_dst_first;
  logic [ADDR_W-1:0] w_step;
  logic              w_last_byte;

  // --------------------------------------------------------------------------
  // Start-time setup. A full-length copy truncates w_len_lo to 0, so the
  // descending start pointer becomes base-1, which is the correct last byte
  // modulo the address space.
  // --------------------------------------------------------------------------
  assign w_len_clamped = (Len > c_FULL_LEN) ? c_FULL_LEN : Len;
  assign w_len_lo      = w_len_clamped[ADDR_W-1:0];
  assign w_desc_start  = (DstAddr > SrcAddr);
  assign w_src_first   = w_desc_start ? (SrcAddr + w_len_lo + c_MINUS_ONE) : SrcAddr;
  assign w_dst_first   = w_desc_start ? (DstAddr + w_len_lo + c_MINUS_ONE) : DstAddr;

  // One step value feeds both pointer adders; its sign comes from the
  // direction latched at Start.
  assign w_step      = r_desc ? c_MINUS_ONE : c_PLUS_ONE;
  assign w_last_byte = (r_count == c_ONE_CNT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. Memory pins depend only on state and
  // registered pointers/hold data, never on Start.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start_copy = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    ReadMem      = 1'b0;
    WriteMem     = 1'b0;
    DataAddress  = '0;
    DataIn       = '0;

    case (r_state)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            w_next_state = READ;
            w_start_copy = 1'b1;
          end else begin
            w_next_state = DONE;
          end
        end
      end

      READ: begin
        Busy         = 1'b1;
        ReadMem      = 1'b1;
        DataAddress  = r_src_ptr;
        w_next_state = WRITE;
      end

      WRITE: begin
        Busy         = 1'b1;
        WriteMem     = 1'b1;
        DataAddress  = r_dst_ptr;
        DataIn       = r_hold;
        w_next_state = w_last_byte ? DONE : READ;
      end

      DONE: begin
        Done         = 1'b1;
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: pointers, remaining count, direction and byte hold register.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_count   <= '0;
      r_desc    <= 1'b0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_copy) begin
            r_src_ptr <= w_src_first;
            r_dst_ptr <= w_dst_first;
            r_count   <= w_len_clamped;
            r_desc    <= w_desc_start;
          end
        end

        READ: begin
          r_hold <= DataOut;
        end

        WRITE: begin
          r_src_ptr <= r_src_ptr + w_step;
          r_dst_ptr <= r_dst_ptr + w_step;
          r_count   <= r_count - c_ONE_CNT;
        end

        default: begin
        end
      endcase
    end
  end

endmodule : mem_copy_dma
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_dma
// Description : Directed self-checking bench for mem_copy_dma with a 256 x 8
//               behavioural memory (combinational read, write on posedge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_dma;

  import dma_pkg::*;

  logic       CLK;
  logic       reset;
  logic       Start;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [8:0] Len;
  logic       Busy;
  logic       Done;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_wa;
  logic [7:0] tb_wd;

  int n_checks;
  int n_fail;

  // Observations collected by run_copy
  int         obs_done_cycle;
  int         obs_done_count;
  int         obs_nreads;
  int         obs_nwrites;
  int         obs_both;
  logic       obs_busy_seen;
  logic [7:0] obs_first_wr;
  logic [7:0] rd_log [8];

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .Start       (Start),
    .SrcAddr     (SrcAddr),
    .DstAddr     (DstAddr),
    .Len         (Len),
    .Busy        (Busy),
    .Done        (Done),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign DataOut = mem[DataAddress];

  always @(posedge CLK) begin
    if (WriteMem) mem[DataAddress] <= DataIn;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge CLK);
    #1 tb_we = 1'b0;
  endtask

  // Launch a copy with Start sampled at edge 0, then observe cycles 1..budget.
  // Inputs are scrambled after the Start edge; an extra Start can be injected.
  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                          input logic [8:0] len, input int budget, input int inject_cycle);
    @(negedge CLK);
    SrcAddr = src; DstAddr = dst; Len = len; Start = 1'b1;
    @(posedge CLK);
    obs_done_cycle = -1; obs_done_count = 0; obs_nreads = 0; obs_nwrites = 0;
    obs_both = 0; obs_busy_seen = 1'b0; obs_first_wr = 8'h00;
    for (int i = 0; i < 8; i++) rd_log[i] = 8'h00;
    for (int c = 1; c <= budget; c++) begin
      @(negedge CLK);
      Start   = (c == inject_cycle);
      SrcAddr = 8'h5A; DstAddr = 8'hA5; Len = 9'd3;
      if (ReadMem && WriteMem) obs_both++;
      if (Busy) obs_busy_seen = 1'b1;
      if (ReadMem) begin
        if (obs_nreads < 8) rd_log[obs_nreads] = DataAddress;
        obs_nreads++;
      end
      if (WriteMem) begin
        if (obs_nwrites == 0) obs_first_wr = DataAddress;
        obs_nwrites++;
      end
      if (Done) begin
        obs_done_count++;
        if (obs_done_cycle < 0) obs_done_cycle = c;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({Busy, Done, ReadMem, WriteMem, DataAddress, DataIn} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b %b %b %b %h %h required all 0", Busy, Done, ReadMem, WriteMem, DataAddress, DataIn);
    end
    n_checks++;
    if (dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required IDLE", dut.r_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_forward;
    wr(8'h10, 8'hA1); wr(8'h11, 8'hB2); wr(8'h12, 8'hC3); wr(8'h13, 8'hD4);
    run_copy(8'h10, 8'h40, 9'd4, 12, 0);
    n_checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hA1B2C3D4) begin
      n_fail++;
      $display("FAIL fwd_data: got %h%h%h%h required a1b2c3d4", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
    n_checks++;
    if (obs_done_cycle !== 9 || obs_done_count !== 1) begin
      n_fail++;
      $display("FAIL fwd_done: got cycle %0d count %0d required cycle 9 count 1", obs_done_cycle, obs_done_count);
    end
    n_checks++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hA1B2C3D4) begin
      n_fail++;
      $display("FAIL fwd_src_intact: got %h%h%h%h required a1b2c3d4", mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
  endtask

  task automatic test_overlap_up;
    wr(8'h20, 8'h01); wr(8'h21, 8'h02); wr(8'h22, 8'h03); wr(8'h23, 8'h04);
    run_copy(8'h20, 8'h21, 9'd4, 12, 0);
    n_checks++;
    if ({mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]} !== 32'h01020304) begin
      n_fail++;
      $display("FAIL ovl_up_data: got %h%h%h%h required 01020304", mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]);
    end
    n_checks++;
    if (obs_first_wr !== 8'h24) begin
      n_fail++;
      $display("FAIL ovl_up_first_write: got %h required 24", obs_first_wr);
    end
  endtask

  task automatic test_overlap_down;
    wr(8'h31, 8'h05); wr(8'h32, 8'h06); wr(8'h33, 8'h07); wr(8'h34, 8'h08);
    run_copy(8'h31, 8'h30, 9'd4, 12, 0);
    n_checks++;
    if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} !== 32'h05060708) begin
      n_fail++;
      $display("FAIL ovl_down_data: got %h%h%h%h required 05060708", mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]);
    end
  endtask

  task automatic test_wrap;
    run_copy(8'hFE, 8'h80, 9'd4, 12, 0);
    n_checks++;
    if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 32'hFEFF0001 || obs_nreads !== 4) begin
      n_fail++;
      $display("FAIL wrap_reads: got %h %h %h %h (n=%0d) required fe ff 00 01 (n=4)", rd_log[0], rd_log[1], rd_log[2], rd_log[3], obs_nreads);
    end
  endtask

  task automatic test_full_length;
    run_copy(8'h00, 8'h00, 9'd256, 516, 0);
    n_checks++;
    if (obs_done_cycle !== 513 || obs_done_count !== 1) begin
      n_fail++;
      $display("FAIL full_done: got cycle %0d count %0d required cycle 513 count 1", obs_done_cycle, obs_done_count);
    end
    n_checks++;
    if (obs_both !== 0 || obs_nwrites !== 256) begin
      n_fail++;
      $display("FAIL full_strobes: got both=%0d writes=%0d required both=0 writes=256", obs_both, obs_nwrites);
    end
    n_checks++;
    if (mem[8'h40] !== 8'hA1 || mem[8'h24] !== 8'h04) begin
      n_fail++;
      $display("FAIL full_selfcopy: got %h %h required a1 04", mem[8'h40], mem[8'h24]);
    end
  endtask

  task automatic test_clamp;
    run_copy(8'h00, 8'h00, 9'd300, 516, 0);
    n_checks++;
    if (obs_done_cycle !== 513 || obs_nwrites !== 256) begin
      n_fail++;
      $display("FAIL clamp: got done cycle %0d writes %0d required 513 and 256", obs_done_cycle, obs_nwrites);
    end
  endtask

  task automatic test_zero_length;
    run_copy(8'h10, 8'h70, 9'd0, 4, 0);
    n_checks++;
    if (obs_done_cycle !== 1 || obs_done_count !== 1) begin
      n_fail++;
      $display("FAIL zero_done: got cycle %0d count %0d required cycle 1 count 1", obs_done_cycle, obs_done_count);
    end
    n_checks++;
    if (obs_nreads !== 0 || obs_nwrites !== 0 || obs_busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_activity: got reads=%0d writes=%0d busy=%b required 0 0 0", obs_nreads, obs_nwrites, obs_busy_seen);
    end
  endtask

  task automatic test_ignored_start;
    run_copy(8'h10, 8'h60, 9'd4, 12, 3);
    n_checks++;
    if ({mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]} !== 32'hA1B2C3D4) begin
      n_fail++;
      $display("FAIL busy_start_data: got %h%h%h%h required a1b2c3d4", mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]);
    end
    n_checks++;
    if (obs_done_cycle !== 9 || obs_done_count !== 1 || obs_nwrites !== 4) begin
      n_fail++;
      $display("FAIL busy_start_timing: got done %0d count %0d writes %0d required 9 1 4", obs_done_cycle, obs_done_count, obs_nwrites);
    end
  endtask

  task automatic test_reset_mid_copy;
    int late_done;
    for (int i = 0; i < 8; i++) wr(8'h90 + 8'(i), 8'h11 + 8'(i));
    run_copy(8'h90, 8'h50, 9'd8, 5, 0);
    reset = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({Busy, Done, ReadMem, WriteMem, DataAddress, DataIn} !== 20'h0 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b %b %b %b %h %h state %0d required all 0 and IDLE", Busy, Done, ReadMem, WriteMem, DataAddress, DataIn, dut.r_state);
    end
    reset = 1'b0;
    late_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (Done || WriteMem) late_done++;
    end
    n_checks++;
    if (late_done !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d Done/Write cycles after reset required 0", late_done);
    end
    n_checks++;
    if (obs_nwrites !== 2 || {mem[8'h50], mem[8'h51], mem[8'h52]} !== 24'h111200) begin
      n_fail++;
      $display("FAIL abort_bytes: got writes %0d mem %h %h %h required 2 and 11 12 00", obs_nwrites, mem[8'h50], mem[8'h51], mem[8'h52]);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; Start = 1'b0; SrcAddr = 8'h00; DstAddr = 8'h00; Len = 9'd0;
    tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;
    for (int a = 0; a < 256; a++) wr(8'(a), 8'h00);
    test_reset;
    test_forward;
    test_overlap_up;
    test_overlap_down;
    test_wrap;
    test_full_length;
    test_clamp;
    test_zero_length;
    test_ignored_start;
    test_reset_mid_copy;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_copy_dma
`default_nettype wire

// File: doc/mem_copy_dma.md
# mem_copy_dma

Block-copy initiator for the 256×8 single-port data memory. It accepts a source address, destination address and length, then drives the memory's address, read-enable, write-enable and write-data pins to copy bytes, two cycles per byte. Overlap-safe (memmove semantics). It sits between the control core and the data memory port, and owns the port while busy.

## Interface
- `ADDR_W`, default 8: memory address width (256 bytes).
- `DATA_W`, default 8: memory data width.
- `CLK` in 1: clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `Start` in 1: request a copy; sampled only in IDLE.
- `SrcAddr` in ADDR_W: first source byte address.
- `DstAddr` in ADDR_W: first destination byte address.
- `Len` in ADDR_W+1: byte count, 0..256; values above 256 are clamped to 256.
- `Busy` out 1: high in READ and WRITE.
- `Done` out 1: one-cycle pulse in DONE.
- `DataAddress` out ADDR_W: memory address.
- `ReadMem` out 1: memory read enable.
- `WriteMem` out 1: memory write enable.
- `DataIn` out DATA_W: memory write data.
- `DataOut` in DATA_W: memory read data. Combinational from the memory; valid in the same cycle as `ReadMem`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `Start`=1 and `Len`≠0 → latch the pointers, the remaining count and the direction, then go to READ.
  - `Start`=1 and `Len`=0 → go to DONE with no memory access.
  - Otherwise stay in IDLE.
- Direction is decided at Start, by unsigned compare:
  - `DstAddr` > `SrcAddr` → descending. Pointers start at `SrcAddr`+`Len`−1 and `DstAddr`+`Len`−1, mod 256.
  - Otherwise → ascending from `SrcAddr` and `DstAddr`.
- READ:
  - Drive `ReadMem`=1 and `DataAddress`=src_ptr.
  - Capture `DataOut` into the hold register at the clock edge.
  - Go to WRITE.
- WRITE:
  - Drive `WriteMem`=1, `DataAddress`=dst_ptr, `DataIn`=hold register.
  - Step both pointers by +1 or −1, mod 256 (wrap 255→0 and 0→255).
  - Decrement the remaining count. If it reaches 0 go to DONE, else go to READ.
- DONE: `Done`=1, then go to IDLE unconditionally.
- `ReadMem` and `WriteMem` are never both high.
- In IDLE and DONE: `DataAddress`=0, `DataIn`=0, `ReadMem`=0, `WriteMem`=0.
- `Start` is ignored outside IDLE. Input changes after Start have no effect on a copy in progress.
- `SrcAddr`=`DstAddr` is legal: the block performs read/write-back of identical data.

## Timing
- Reset values: state IDLE; `Busy`=0, `Done`=0, `ReadMem`=0, `WriteMem`=0, `DataAddress`=0, `DataIn`=0; hold register, pointers and count all 0.
- Reset while in READ or WRITE aborts the copy at that edge. Bytes already written remain written, unless the memory shares the reset.
- Cycle numbering, for `Start` sampled at edge 0:
  - Cycle 1 is READ of byte 0; cycle 2 is WRITE of byte 0.
  - Byte k is read in cycle 2k+1 and written in cycle 2k+2.
  - `Done` is high in cycle 2·`Len`+1.
  - Earliest next Start is sampled at the end of cycle 2·`Len`+2.
- `Len`=0: `Done` high in cycle 1 and `Busy` never rises.
- All outputs are registered or decoded from state only. There is no combinational path from `Start` to any memory pin.

## Structure
- Package `dma_pkg`: `dma_state_t` enum {IDLE, READ, WRITE, DONE}, plus `ADDR_W` and `DATA_W` constants.
- Single module; no sub-module is warranted.
- The pointer step is a shared ±1 adder whose sign is selected by the latched direction bit.

## Test plan
- Forward copy:
  - Stimulus: M[0x10..0x13]={A1,B2,C3,D4}, Src=0x10, Dst=0x40, Len=4.
  - Required: M[0x40..0x43]={A1,B2,C3,D4}; `Done` in cycle 9; source bytes unchanged.
- Overlap, Dst > Src:
  - Stimulus: M[0x20..0x23]={1,2,3,4}, Src=0x20, Dst=0x21, Len=4.
  - Required: M[0x21..0x24]={1,2,3,4}; first write lands at 0x24.
- Overlap, Dst < Src:
  - Stimulus: M[0x31..0x34]={5,6,7,8}, Src=0x31, Dst=0x30, Len=4.
  - Required: M[0x30..0x33]={5,6,7,8}.
- Wrap and full length:
  - Src=0xFE, Dst=0x80, Len=4 → source reads at 0xFE, 0xFF, 0x00, 0x01.
  - Len=256, Src=0x00, Dst=0x00 → `Done` in cycle 513; `ReadMem` and `WriteMem` never both high.
- Zero length and ignored Start:
  - Len=0 → `Done` in cycle 1; no `ReadMem` or `WriteMem` activity.
  - `Start` pulsed while `Busy` → ignored; the in-flight copy is unaffected.
- Reset mid-copy:
  - Stimulus: Len=8, assert `reset` in cycle 5.
  - Required: next cycle all outputs 0 and state IDLE; exactly bytes 0 and 1 are written; no `Done` pulse.
